// File: rtl/branch_resolve_ctrl.sv
// Branch resolution, PC redirect and 2-bit BHT direction predictor for the RV32I pipe.
// Redirect/flush are combinational in the resolve cycle; stall_e holds resolution off until it drops.
module branch_resolve_ctrl #(
    parameter int BHT_IDX_W = 6,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      PCF,
    output logic             pred_taken_f,
    input  logic             valid_e,
    input  logic             stall_e,
    input  logic [6:0]       instr_opcode_e,
    input  logic [31:0]      PCE,
    input  logic [31:0]      PCPlus4E,
    input  logic [31:0]      PCTargetE,
    input  logic             br_taken_e,
    input  logic             pred_taken_e,
    output logic             redirect,
    output logic [31:0]      redirect_pc,
    output logic             flush_d,
    output logic             flush_e,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam int BHT_DEPTH = 1 << BHT_IDX_W;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic {IDLE, RECOVER} state_t;

    state_t state, state_nxt;
    logic [1:0] bht [BHT_DEPTH];

    logic [BHT_IDX_W-1:0] idx_f, idx_e;
    logic is_branch, is_jump, resolve, mispred;

    assign idx_f = PCF[BHT_IDX_W+1:2];
    assign idx_e = PCE[BHT_IDX_W+1:2];

    logic unused_pc_bits;
    assign unused_pc_bits = &{1'b0, PCF[31:BHT_IDX_W+2], PCF[1:0], PCE[31:BHT_IDX_W+2], PCE[1:0]};

    // Table write lands at the edge, so a same-cycle fetch sees the old entry.
    assign pred_taken_f = bht[idx_f][1];

    assign is_branch = (instr_opcode_e == OP_BRANCH);
    assign is_jump   = (instr_opcode_e == OP_JAL) || (instr_opcode_e == OP_JALR);

    always_comb begin
        resolve     = 1'b0;
        mispred     = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        state_nxt   = state;
        case (state)
            IDLE: begin
                resolve  = valid_e && !stall_e;
                mispred  = resolve && is_branch && (br_taken_e != pred_taken_e);
                redirect = mispred || (resolve && is_jump);
                if (redirect) begin
                    redirect_pc = (is_jump || br_taken_e) ? PCTargetE : PCPlus4E;
                    state_nxt   = RECOVER;
                end
            end
            // The bubble behind a redirect must never resolve.
            RECOVER: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign flush_d = redirect;
    assign flush_e = redirect;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht[i] <= 2'b01;
            end
        end else if (resolve && is_branch) begin
            if (br_taken_e) begin
                if (bht[idx_e] != 2'b11) bht[idx_e] <= bht[idx_e] + 2'b01;
            end else begin
                if (bht[idx_e] != 2'b00) bht[idx_e] <= bht[idx_e] - 2'b01;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else if (resolve && is_branch) begin
            if (branch_cnt != '1) branch_cnt <= branch_cnt + CNT_W'(1);
            if (mispred && (mispred_cnt != '1)) mispred_cnt <= mispred_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed bench for branch_resolve_ctrl; a second instance with 4-bit counters shares the stimulus.
module tb_branch_resolve_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PCF;
    logic        valid_e, stall_e;
    logic [6:0]  instr_opcode_e;
    logic [31:0] PCE, PCPlus4E, PCTargetE;
    logic        br_taken_e, pred_taken_e;

    logic        pred_taken_f, redirect, flush_d, flush_e;
    logic [31:0] redirect_pc, branch_cnt, mispred_cnt;

    logic        pred_taken_f4, redirect4, flush_d4, flush_e4;
    logic [31:0] redirect_pc4;
    logic [3:0]  branch_cnt4, mispred_cnt4;

    int n_chk  = 0;
    int n_pass = 0;

    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    always #5 clk = ~clk;

    branch_resolve_ctrl dut (
        .clk(clk), .rst(rst), .PCF(PCF), .pred_taken_f(pred_taken_f),
        .valid_e(valid_e), .stall_e(stall_e), .instr_opcode_e(instr_opcode_e),
        .PCE(PCE), .PCPlus4E(PCPlus4E), .PCTargetE(PCTargetE),
        .br_taken_e(br_taken_e), .pred_taken_e(pred_taken_e),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .flush_d(flush_d), .flush_e(flush_e),
        .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    branch_resolve_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .PCF(PCF), .pred_taken_f(pred_taken_f4),
        .valid_e(valid_e), .stall_e(stall_e), .instr_opcode_e(instr_opcode_e),
        .PCE(PCE), .PCPlus4E(PCPlus4E), .PCTargetE(PCTargetE),
        .br_taken_e(br_taken_e), .pred_taken_e(pred_taken_e),
        .redirect(redirect4), .redirect_pc(redirect_pc4),
        .flush_d(flush_d4), .flush_e(flush_e4),
        .branch_cnt(branch_cnt4), .mispred_cnt(mispred_cnt4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Advance one edge; inputs change 1 time unit later, outputs settle before the next check.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic vld, input logic [6:0] op, input logic [31:0] pc,
                             input logic [31:0] tgt, input logic tk, input logic pr);
        valid_e        = vld;
        instr_opcode_e = op;
        PCE            = pc;
        PCPlus4E       = pc + 32'd4;
        PCTargetE      = tgt;
        br_taken_e     = tk;
        pred_taken_e   = pr;
        #1;
    endtask

    initial begin
        rst = 1'b1; PCF = 32'h40; stall_e = 1'b0;
        set_instr(1'b0, 7'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        step(); step();
        rst = 1'b0;
        #1;
        chk("rst_pred_f",   {31'h0, pred_taken_f}, 32'd0);
        chk("rst_br_cnt",   branch_cnt, 32'd0);
        chk("rst_mp_cnt",   mispred_cnt, 32'd0);
        chk("rst_redirect", {31'h0, redirect}, 32'd0);
        chk("rst_rpc",      redirect_pc, 32'd0);

        // BEQ predicted not-taken, resolves taken
        set_instr(1'b1, OP_BR, 32'h40, 32'h80, 1'b1, 1'b0);
        chk("beq_redirect", {31'h0, redirect}, 32'd1);
        chk("beq_rpc",      redirect_pc, 32'h80);
        chk("beq_flush",    {30'h0, flush_d, flush_e}, 32'd3);
        step();
        chk("recov_redirect", {31'h0, redirect}, 32'd0);
        chk("recov_flush",    {30'h0, flush_d, flush_e}, 32'd0);
        chk("recov_rpc",      redirect_pc, 32'd0);
        chk("beq_br_cnt",     branch_cnt, 32'd1);
        chk("beq_mp_cnt",     mispred_cnt, 32'd1);
        chk("beq_pred_f",     {31'h0, pred_taken_f}, 32'd1);
        step();
        chk("recov_no_cnt",   branch_cnt, 32'd1);

        // Correctly predicted taken x3 drives entry to saturation
        set_instr(1'b1, OP_BR, 32'h40, 32'h80, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            chk("tk_no_redirect", {31'h0, redirect}, 32'd0);
            step();
        end
        chk("tk3_br_cnt", branch_cnt, 32'd4);
        chk("tk3_mp_cnt", mispred_cnt, 32'd1);

        // Not taken while predicted taken: 11 -> 10
        set_instr(1'b1, OP_BR, 32'h40, 32'h80, 1'b0, 1'b1);
        chk("nt_redirect", {31'h0, redirect}, 32'd1);
        chk("nt_rpc",      redirect_pc, 32'h44);
        step();
        set_instr(1'b0, OP_BR, 32'h40, 32'h80, 1'b0, 1'b1);
        chk("nt_br_cnt", branch_cnt, 32'd5);
        chk("nt_mp_cnt", mispred_cnt, 32'd2);
        chk("nt_pred_f", {31'h0, pred_taken_f}, 32'd1);
        step();
        // Second not-taken: 10 -> 01, so saturation held at 11 earlier
        set_instr(1'b1, OP_BR, 32'h40, 32'h80, 1'b0, 1'b0);
        chk("nt2_no_redirect", {31'h0, redirect}, 32'd0);
        step();
        set_instr(1'b0, OP_BR, 32'h40, 32'h80, 1'b0, 1'b0);
        chk("nt2_pred_f", {31'h0, pred_taken_f}, 32'd0);
        chk("nt2_br_cnt", branch_cnt, 32'd6);

        // JAL always redirects, bubble behind it ignored
        set_instr(1'b1, OP_JAL, 32'h100, 32'h200, 1'b0, 1'b0);
        chk("jal_redirect", {31'h0, redirect}, 32'd1);
        chk("jal_rpc",      redirect_pc, 32'h200);
        step();
        set_instr(1'b1, OP_BR, 32'h40, 32'h80, 1'b1, 1'b0);
        chk("jal_recov_redirect", {31'h0, redirect}, 32'd0);
        chk("jal_br_cnt", branch_cnt, 32'd6);
        chk("jal_mp_cnt", mispred_cnt, 32'd2);
        step();
        set_instr(1'b0, OP_BR, 32'h40, 32'h80, 1'b1, 1'b0);
        chk("jal_recov_br_cnt", branch_cnt, 32'd6);
        chk("jal_pred_f", {31'h0, pred_taken_f}, 32'd0);

        // Mispredicting BNE held by a 3-cycle stall
        stall_e = 1'b1;
        set_instr(1'b1, OP_BR, 32'h40, 32'h80, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("stall_no_redirect", {31'h0, redirect}, 32'd0);
            step();
        end
        chk("stall_br_cnt", branch_cnt, 32'd6);
        stall_e = 1'b0;
        #1;
        chk("unstall_redirect", {31'h0, redirect}, 32'd1);
        chk("unstall_rpc",      redirect_pc, 32'h80);
        step();
        chk("unstall_recov", {31'h0, redirect}, 32'd0);
        set_instr(1'b0, OP_BR, 32'h40, 32'h80, 1'b1, 1'b0);
        step();
        chk("unstall_br_cnt", branch_cnt, 32'd7);
        chk("unstall_mp_cnt", mispred_cnt, 32'd3);
        chk("unstall_pred_f", {31'h0, pred_taken_f}, 32'd1);

        // Reset coincident with a resolving mispredict
        set_instr(1'b1, OP_BR, 32'h40, 32'h80, 1'b1, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        set_instr(1'b0, OP_BR, 32'h40, 32'h80, 1'b1, 1'b0);
        chk("rstc_br_cnt", branch_cnt, 32'd0);
        chk("rstc_mp_cnt", mispred_cnt, 32'd0);
        chk("rstc_pred_f", {31'h0, pred_taken_f}, 32'd0);
        set_instr(1'b1, OP_BR, 32'h40, 32'h80, 1'b1, 1'b0);
        chk("rstc_idle_redirect", {31'h0, redirect}, 32'd1);
        step();
        set_instr(1'b0, OP_BR, 32'h40, 32'h80, 1'b0, 1'b0);
        step();

        // Counter saturation on the 4-bit instance
        rst = 1'b1;
        step();
        rst = 1'b0;
        set_instr(1'b1, OP_BR, 32'h80, 32'hC0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step();
        set_instr(1'b0, OP_BR, 32'h80, 32'hC0, 1'b0, 1'b0);
        chk("sat4_br_cnt",  {28'h0, branch_cnt4}, 32'd15);
        chk("sat4_mp_cnt",  {28'h0, mispred_cnt4}, 32'd0);
        chk("sat32_br_cnt", branch_cnt, 32'd20);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/branch_resolve_ctrl.md
Name: branch_resolve_ctrl

Overview:
- Branch resolution and redirect controller for the 5-stage RV32I pipeline.
- Holds a 2-bit saturating branch history table (BHT) that supplies a direction prediction to fetch.
- Takes the execute-stage branch outcome (br_taken from the branch-condition unit) and compares it with the prediction carried down the pipe.
- On a mismatch, or on any JAL/JALR, it drives PC redirect and decode/execute flushes, then updates the BHT and branch statistics.

Parameters:
- BHT_IDX_W, 6, BHT index width; the table has 2**BHT_IDX_W entries and is indexed by PC[BHT_IDX_W+1:2].
- CNT_W, 32, width of the saturating statistics counters.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- PCF  in  32  fetch-stage PC.
- pred_taken_f  out  1  predicted direction for PCF.
- valid_e  in  1  execute stage holds a real instruction (not a bubble).
- stall_e  in  1  execute stage stalled by the hazard unit.
- instr_opcode_e  in  7  execute-stage opcode.
- PCE  in  32  execute-stage PC.
- PCPlus4E  in  32  PCE+4.
- PCTargetE  in  32  computed branch/jump target.
- br_taken_e  in  1  resolved outcome from the branch-condition unit.
- pred_taken_e  in  1  prediction piped from fetch.
- redirect  out  1  PC mux select to redirect_pc.
- redirect_pc  out  32  corrected next PC.
- flush_d  out  1  clear the IF/ID register at the next edge.
- flush_e  out  1  clear the ID/EX register at the next edge.
- branch_cnt  out  CNT_W  resolved conditional branches.
- mispred_cnt  out  CNT_W  mispredicted conditional branches.

Behaviour:
- Reset values:
  - All BHT entries = 2'b01 (weakly not-taken).
  - branch_cnt = 0, mispred_cnt = 0.
  - State = IDLE.
  - redirect, flush_d, flush_e = 0; redirect_pc = 0.
- Prediction:
  - pred_taken_f is combinational and equals bit 1 of BHT[PCF[BHT_IDX_W+1:2]].
  - A BHT write in the same cycle to the same index is not visible until after the edge (old value is read).
- Resolve condition (resolve): state == IDLE & valid_e & ~stall_e.
- Instruction classes:
  - Conditional branch: opcode 1100011.
  - Jump: opcode 1101111 (JAL) or 1100111 (JALR).
- Mispredict (mispred): resolve & branch & (br_taken_e != pred_taken_e).
- Redirect (combinational, same cycle as resolve):
  - redirect = mispred | (resolve & jump).
  - redirect_pc = PCTargetE if (jump | br_taken_e), else PCPlus4E.
  - When redirect is 0, redirect_pc = 0.
- Flushes: flush_d = flush_e = redirect.
- Jumps always redirect (no target buffer). They do not touch the BHT or the counters.
- On each edge with resolve & branch:
  - BHT[PCE[BHT_IDX_W+1:2]] increments, saturating at 2'b11, if br_taken_e; otherwise it decrements, saturating at 2'b00.
  - branch_cnt increments, saturating at all-ones.
  - mispred_cnt increments (saturating) if mispred.
- FSM:
  - IDLE -> RECOVER on any edge where redirect = 1.
  - RECOVER -> IDLE unconditionally after 1 cycle.
  - In RECOVER, resolve is forced to 0: no redirect, no flush, no BHT or counter update, whatever valid_e/br_taken_e are. This guards the flushed bubble.
- Stalls:
  - stall_e = 1 blocks resolve.
  - An instruction held across N stall cycles resolves exactly once, in the first cycle stall_e = 0.
  - stall_e does not advance the FSM out of IDLE. RECOVER still exits after 1 cycle.
- Non-branch, non-jump opcodes and valid_e = 0 produce no action.
- Reset mid-RECOVER, or coincident with a redirect: reset wins. State goes to IDLE, and the BHT and counters take their reset values at that edge.

Test Plan:
- Reset, then PCF=0x40: pred_taken_f=0; branch_cnt=0, mispred_cnt=0; redirect=0.
- BEQ at PCE=0x40, pred_taken_e=0, br_taken_e=1, PCTargetE=0x80: same cycle redirect=1, redirect_pc=0x80, flush_d=flush_e=1. Next cycle state RECOVER with all outputs 0. branch_cnt=1, mispred_cnt=1, BHT[16]=2'b10, and PCF=0x40 then gives pred_taken_f=1.
- Same branch resolved taken 3 more times with pred_taken_e=1: no redirect; BHT[16] saturates at 2'b11; branch_cnt=4, mispred_cnt=1. Then br_taken_e=0, PCPlus4E=0x44: redirect_pc=0x44; BHT[16]=2'b10.
- JAL at PCE=0x100, PCTargetE=0x200: redirect=1, redirect_pc=0x200; counters and BHT unchanged. Another valid branch in the following cycle (RECOVER) is ignored.
- Mispredicting BNE held with stall_e=1 for 3 cycles: no redirect while stalled. Redirect occurs exactly once in the first cycle stall_e drops; mispred_cnt increments by 1.
- rst asserted in the cycle a mispredict resolves: after the edge state=IDLE, counters=0, BHT entry=2'b01. Also check with CNT_W=4: 20 branches leave branch_cnt=15.
